// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. It runs one data-bus transaction at a
// time over a req/ack handshake, steers byte lanes for stores, and extracts
// and extends load data. Non-memory ops pass straight through to mem/wb.
module mem_lsu #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] reg2_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        stall_req_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);

   // Memory-op encodings on the ALU op bus
   localparam logic [7:0] EXE_LB  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU = 8'b1110_0101;
   localparam logic [7:0] EXE_SB  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW  = 8'b1110_1011;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [7:0]       op_reg;
   logic [1:0]       off_reg;
   logic             store_reg;
   logic [31:0]      cap_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic        is_load;
   logic        is_store;
   logic        is_half;
   logic        is_word;
   logic        misaligned;
   logic        mem_op;
   logic [3:0]  sel_next;
   logic [31:0] lane_wdata;
   logic [7:0]  cap_byte [4];
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic [31:0] load_ext;

   // Decode the incoming op into direction and access size
   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_half  = 1'b0;
      is_word  = 1'b0;
      case (aluop_i)
         EXE_LB, EXE_LBU: is_load = 1'b1;
         EXE_LH, EXE_LHU: begin is_load = 1'b1; is_half = 1'b1; end
         EXE_LW:          begin is_load = 1'b1; is_word = 1'b1; end
         EXE_SB:          is_store = 1'b1;
         EXE_SH:          begin is_store = 1'b1; is_half = 1'b1; end
         EXE_SW:          begin is_store = 1'b1; is_word = 1'b1; end
         default:         ;
      endcase
   end

   assign misaligned = (is_load | is_store) &
                       ((is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00)));
   assign mem_op     = (is_load | is_store) & ~misaligned;

   // Byte-lane enables and lane-replicated store data for the bus request
   always_comb begin
      if (is_word) begin
         sel_next   = 4'b1111;
         lane_wdata = reg2_i;
      end else if (is_half) begin
         sel_next   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
         lane_wdata = {2{reg2_i[15:0]}};
      end else begin
         sel_next   = 4'b0001 << mem_addr_i[1:0];
         lane_wdata = {4{reg2_i[7:0]}};
      end
   end

   // Split the captured read word into byte lanes for offset selection
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cap_byte
         assign cap_byte[gi] = cap_reg[8*gi +: 8];
      end
   endgenerate

   assign byte_val = cap_byte[off_reg];
   assign half_val = off_reg[1] ? cap_reg[31:16] : cap_reg[15:0];

   // Extend captured load data according to the op latched at request time
   always_comb begin
      case (op_reg)
         EXE_LB:  load_ext = {{24{byte_val[7]}}, byte_val};
         EXE_LBU: load_ext = {24'h0, byte_val};
         EXE_LH:  load_ext = {{16{half_val[15]}}, half_val};
         EXE_LHU: load_ext = {16'h0, half_val};
         default: load_ext = cap_reg;
      endcase
   end

   // Pipeline-facing outputs: pass-through, stall, bubble and load writeback
   always_comb begin
      wd_o        = wd_i;
      wreg_o      = wreg_i;
      wdata_o     = wdata_i;
      stall_req_o = 1'b0;
      misalign_o  = 1'b0;
      if (!rst) begin
         wd_o    = 5'd0;
         wreg_o  = 1'b0;
         wdata_o = 32'd0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (misaligned) begin
                  misalign_o = 1'b1;
                  wreg_o     = 1'b0;
               end else if (mem_op) begin
                  stall_req_o = 1'b1;
                  wreg_o      = 1'b0;
                  wdata_o     = 32'd0;
               end
            end
            S_BUS: begin
               stall_req_o = 1'b1;
               wreg_o      = 1'b0;
               wdata_o     = 32'd0;
            end
            S_DONE: begin
               if (store_reg) begin
                  wreg_o  = 1'b0;
                  wdata_o = 32'd0;
               end else begin
                  wdata_o = load_ext;
               end
            end
            default: ;
         endcase
      end
   end

   // Bus FSM: issue the request, wait for ack or timeout, then present result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= S_IDLE;
         op_reg      <= 8'd0;
         off_reg     <= 2'd0;
         store_reg   <= 1'b0;
         cap_reg     <= 32'd0;
         cnt_reg     <= '0;
         bus_err_o   <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 32'd0;
         mem_sel_o   <= 4'd0;
         mem_wdata_o <= 32'd0;
      end else begin
         bus_err_o <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (mem_op) begin
                  state_reg   <= S_BUS;
                  op_reg      <= aluop_i;
                  off_reg     <= mem_addr_i[1:0];
                  store_reg   <= is_store;
                  cnt_reg     <= '0;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= is_store;
                  mem_addr_o  <= {mem_addr_i[31:2], 2'b00};
                  mem_sel_o   <= sel_next;
                  mem_wdata_o <= lane_wdata;
               end
            end
            S_BUS: begin
               if (mem_ack_i) begin
                  cap_reg   <= mem_rdata_i;
                  mem_req_o <= 1'b0;
                  state_reg <= S_DONE;
               end else if (cnt_reg == CNT_LAST) begin
                  cap_reg   <= 32'd0;
                  mem_req_o <= 1'b0;
                  bus_err_o <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_DONE:  state_reg <= S_IDLE;
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized scoreboard bench for mem_lsu. The driver issues ops
// and queues expected writeback and bus requests; independent monitors pop
// and compare; a responder process answers bus requests from a plan queue.
module tb_mem_lsu;

   localparam logic [7:0] EXE_LB  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU = 8'b1110_0101;
   localparam logic [7:0] EXE_SB  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW  = 8'b1110_1011;
   localparam logic [7:0] EXE_OR  = 8'b0010_0101;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  wd_i = 5'd0;
   logic        wreg_i = 1'b0;
   logic [31:0] wdata_i = 32'd0;
   logic [7:0]  aluop_i = 8'd0;
   logic [31:0] mem_addr_i = 32'd0;
   logic [31:0] reg2_i = 32'd0;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stall_req_o;
   logic        misalign_o;
   logic        bus_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = 32'd0;

   always #5 clk = ~clk;

   mem_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
      .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .stall_req_o(stall_req_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      bit          chk_wdata;
      logic        mis;
      logic        err;
   } ret_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] wdata;
      int          cyc;
      bit          chk_cyc;
   } bus_t;

   typedef struct {
      int          delay;
      logic [31:0] rdata;
   } plan_t;

   ret_t  ret_q[$];
   bus_t  bus_q[$];
   plan_t plan_q[$];

   int checks = 0;
   int fails  = 0;
   bit mon_en = 1'b0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference load result: pick the addressed byte/half and extend it
   function automatic logic [31:0] load_model(input logic [7:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      logic [31:0] b;
      logic [31:0] h;
      b = (rdata >> (8 * addr[1:0])) & 32'hFF;
      h = (rdata >> (16 * addr[1])) & 32'hFFFF;
      case (op)
         EXE_LB:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
         EXE_LBU: return b;
         EXE_LH:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
         EXE_LHU: return h;
         default: return rdata;
      endcase
   endfunction

   // Issue one op, queue its expected results, hold it until it retires
   task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] alu, input logic [4:0] wd, input logic wr,
                        input int delay, input logic [31:0] rdata);
      int    size;
      bit    ld;
      bit    st;
      bit    mis;
      bit    tmo;
      int    exp_stall;
      int    stall_n;
      ret_t  r;
      bus_t  b;
      plan_t p;
      size = 0; ld = 0; st = 0;
      case (op)
         EXE_LB, EXE_LBU: begin ld = 1; size = 1; end
         EXE_LH, EXE_LHU: begin ld = 1; size = 2; end
         EXE_LW:          begin ld = 1; size = 4; end
         EXE_SB:          begin st = 1; size = 1; end
         EXE_SH:          begin st = 1; size = 2; end
         EXE_SW:          begin st = 1; size = 4; end
         default:         ;
      endcase
      mis = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
      tmo = (delay < 0);
      r.wd = wd; r.wreg = wr; r.wdata = alu; r.chk_wdata = 1; r.mis = 0; r.err = 0;
      exp_stall = 0;
      if (ld || st) begin
         if (mis) begin
            r.wreg = 0; r.mis = 1; r.chk_wdata = 0;
         end else begin
            exp_stall = tmo ? 17 : delay + 2;
            b.addr    = addr & 32'hFFFF_FFFC;
            b.we      = st;
            b.cyc     = tmo ? 16 : delay + 1;
            b.chk_cyc = 1;
            if (size == 4) begin
               b.sel = 4'hF; b.wdata = reg2;
            end else if (size == 2) begin
               b.sel = addr[1] ? 4'hC : 4'h3; b.wdata = (reg2 & 32'hFFFF) * 32'h0001_0001;
            end else begin
               b.sel = 4'(1 << addr[1:0]); b.wdata = (reg2 & 32'hFF) * 32'h0101_0101;
            end
            bus_q.push_back(b);
            p.delay = delay; p.rdata = rdata;
            plan_q.push_back(p);
            r.err = tmo;
            if (ld) r.wdata = tmo ? 32'd0 : load_model(op, addr, rdata);
            else begin r.wreg = 0; r.chk_wdata = 0; end
         end
      end
      ret_q.push_back(r);
      aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wdata_i = alu; wd_i = wd; wreg_i = wr;
      stall_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!stall_req_o) break;
         stall_n++;
      end
      check32("stall_cycles", stall_n, exp_stall);
      $display("op %h addr %h delay %0d stall %0d", op, addr, delay, stall_n);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      check32("rst_req",   {31'd0, mem_req_o}, 32'd0);
      check32("rst_we",    {31'd0, mem_we_o}, 32'd0);
      check32("rst_sel",   {28'd0, mem_sel_o}, 32'd0);
      check32("rst_addr",  mem_addr_o, 32'd0);
      check32("rst_bwd",   mem_wdata_o, 32'd0);
      check32("rst_stall", {31'd0, stall_req_o}, 32'd0);
      check32("rst_mis",   {31'd0, misalign_o}, 32'd0);
      check32("rst_err",   {31'd0, bus_err_o}, 32'd0);
      check32("rst_wd",    {27'd0, wd_o}, 32'd0);
      check32("rst_wreg",  {31'd0, wreg_o}, 32'd0);
      check32("rst_wdata", wdata_o, 32'd0);
   endtask

   // Retirement monitor: every non-stalled cycle presents one op's result
   ret_t mon_r;
   always @(negedge clk) begin
      if (mon_en && rst && !stall_req_o) begin
         if (ret_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL retire_unexpected: got wd %h expected none", wd_o);
         end else begin
            mon_r = ret_q.pop_front();
            check32("ret_wd",   {27'd0, wd_o}, {27'd0, mon_r.wd});
            check32("ret_wreg", {31'd0, wreg_o}, {31'd0, mon_r.wreg});
            check32("ret_mis",  {31'd0, misalign_o}, {31'd0, mon_r.mis});
            check32("ret_err",  {31'd0, bus_err_o}, {31'd0, mon_r.err});
            if (mon_r.chk_wdata) check32("ret_wdata", wdata_o, mon_r.wdata);
         end
      end
   end

   // Bus monitor: check each request when it rises, its stability and its length
   bus_t bus_cur;
   bit   bus_active = 1'b0;
   int   bus_cyc = 0;
   always @(negedge clk) begin
      if (!rst) begin
         bus_active = 1'b0;
      end else if (mem_req_o && !bus_active) begin
         if (bus_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL bus_unexpected: got req addr %h expected no request", mem_addr_o);
            bus_cur.addr = mem_addr_o; bus_cur.sel = mem_sel_o; bus_cur.we = mem_we_o;
            bus_cur.wdata = mem_wdata_o; bus_cur.cyc = 0; bus_cur.chk_cyc = 0;
         end else begin
            bus_cur = bus_q.pop_front();
            check32("bus_addr",  mem_addr_o, bus_cur.addr);
            check32("bus_sel",   {28'd0, mem_sel_o}, {28'd0, bus_cur.sel});
            check32("bus_we",    {31'd0, mem_we_o}, {31'd0, bus_cur.we});
            check32("bus_wdata", mem_wdata_o, bus_cur.wdata);
         end
         bus_active = 1'b1;
         bus_cyc    = 1;
      end else if (mem_req_o && bus_active) begin
         bus_cyc++;
         check32("bus_hold", {mem_addr_o[31:4], mem_sel_o, mem_we_o, 3'd0} ^ mem_wdata_o,
                 {bus_cur.addr[31:4], bus_cur.sel, bus_cur.we, 3'd0} ^ bus_cur.wdata);
      end else if (!mem_req_o && bus_active) begin
         bus_active = 1'b0;
         if (bus_cur.chk_cyc) check32("bus_cycles", bus_cyc, bus_cur.cyc);
      end
   end

   // Bus responder: ack per plan, plus stray acks while no request is open
   plan_t resp_plan;
   bit    resp_active = 1'b0;
   int    resp_cnt = 0;
   always begin
      @(posedge clk);
      #1;
      mem_ack_i = 1'b0;
      if (!rst) begin
         resp_active = 1'b0;
      end else if (mem_req_o) begin
         if (!resp_active) begin
            resp_active = 1'b1;
            resp_cnt    = 0;
            if (plan_q.size() > 0) resp_plan = plan_q.pop_front();
            else begin resp_plan.delay = 0; resp_plan.rdata = 32'd0; end
         end
         if (resp_plan.delay >= 0 && resp_cnt == resp_plan.delay) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = resp_plan.rdata;
            resp_active = 1'b0;
         end else begin
            resp_cnt++;
         end
      end else begin
         resp_active = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = $urandom;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] op_tab [9];
   bus_t       rb;
   plan_t      rp;

   initial begin
      int k;
      int dly;
      op_tab[0] = EXE_OR; op_tab[1] = EXE_LB; op_tab[2] = EXE_LH; op_tab[3] = EXE_LW;
      op_tab[4] = EXE_LBU; op_tab[5] = EXE_LHU; op_tab[6] = EXE_SB; op_tab[7] = EXE_SH;
      op_tab[8] = EXE_SW;

      // Reset held with live pass-through inputs: outputs must all read zero
      aluop_i = EXE_OR; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst    = 1'b1;
      mon_en = 1'b1;

      do_op(EXE_OR,  32'h0,   32'h0,        32'hCAFE_F00D, 5'd7, 1'b1, 0, 32'h0);
      do_op(EXE_LW,  32'h100, 32'h0,        32'h0,         5'd3, 1'b1, 0, 32'hDEAD_BEEF);
      do_op(EXE_LB,  32'h103, 32'h0,        32'h0,         5'd4, 1'b1, 2, 32'h8011_2233);
      do_op(EXE_LBU, 32'h103, 32'h0,        32'h0,         5'd5, 1'b1, 1, 32'h8011_2233);
      do_op(EXE_SH,  32'h202, 32'h0000_ABCD, 32'h0,        5'd6, 1'b1, 0, 32'h0);
      do_op(EXE_LW,  32'h101, 32'h0,        32'h0,         5'd8, 1'b1, 0, 32'h0);
      do_op(EXE_LW,  32'h104, 32'h0,        32'h0,         5'd9, 1'b1, -1, 32'h0);
      do_op(EXE_LH,  32'h206, 32'h0,        32'h0,         5'd10, 1'b1, 3, 32'h9ABC_0001);

      for (int n = 0; n < 150; n++) begin
         k   = $urandom_range(0, 8);
         dly = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 5));
         do_op(op_tab[k], $urandom & 32'h0000_0FFF, $urandom, $urandom,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), dly, $urandom);
      end

      // Reset while a load waits for an ack that never comes
      mon_en = 1'b0;
      rb.addr = 32'h300; rb.sel = 4'hF; rb.we = 1'b0; rb.wdata = 32'h0;
      rb.cyc = 0; rb.chk_cyc = 0;
      bus_q.push_back(rb);
      rp.delay = -1; rp.rdata = 32'h0;
      plan_q.push_back(rp);
      aluop_i = EXE_LW; mem_addr_i = 32'h300; reg2_i = 32'h0; wd_i = 5'd2; wreg_i = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_reset_outputs();
      $display("reset during BUS: req %b stall %b", mem_req_o, stall_req_o);
      @(posedge clk);
      #1;
      aluop_i = EXE_OR;
      rst     = 1'b1;
      mon_en  = 1'b1;
      do_op(EXE_OR, 32'h0,   32'h0, 32'h0BAD_CAFE, 5'd11, 1'b1, 0, 32'h0);
      do_op(EXE_LHU, 32'h402, 32'h0, 32'h0,        5'd12, 1'b1, 1, 32'hF00D_1234);
      mon_en = 1'b0;

      check32("queues_drained", ret_q.size() + bus_q.size() + plan_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
